// File: rtl/ov7670_sccb_config.sv
`default_nettype none
// ============================================================================
// Module      : ov7670_sccb_config
// Description : Walks an internal {reg,val} table and writes each entry to the
//               OV7670 over 3-phase SCCB. It supports delay and end markers.
//               The optional camera power-up sequence is enabled by defining
//               OV7670_PWR_SEQ_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ov7670_sccb_config #(
    parameter int         CLK_FREQ_HZ  = 50_000_000,
    parameter int         SCCB_FREQ_HZ = 100_000,
    parameter logic [7:0] DEV_ADDR     = 8'h42,
    parameter int         DELAY_MS     = 10,
    parameter int         GAP_QTR      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       sioc,
    output logic       siod_oe,
    output logic       busy,
    output logic       done,
    output logic [7:0] rom_idx
`ifdef OV7670_PWR_SEQ_EN
    ,
    output logic       cam_pwdn,
    output logic       cam_resetb
`endif
);

    localparam int              c_QDIV_RAW  = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
    localparam int              c_QDIV      = (c_QDIV_RAW < 1) ? 1 : c_QDIV_RAW;
    localparam int              c_QW        = (c_QDIV > 1) ? $clog2(c_QDIV) : 1;
    localparam logic [c_QW-1:0] c_QRELOAD   = c_QW'(c_QDIV - 1);
    localparam longint          c_WAIT_RAW  = longint'(DELAY_MS) * longint'(CLK_FREQ_HZ) / 1000;
    localparam logic [31:0]     c_WAIT_LOAD = (c_WAIT_RAW < 1) ? 32'd0 : 32'(c_WAIT_RAW - 1);
    localparam logic [31:0]     c_GAP_LOAD  = (GAP_QTR < 1) ? 32'd0 : 32'(GAP_QTR - 1);
`ifdef OV7670_PWR_SEQ_EN
    localparam logic [31:0]     c_MS_LOAD   = (CLK_FREQ_HZ < 2000) ? 32'd0 : 32'(CLK_FREQ_HZ / 1000 - 1);
`endif

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_FETCH = 4'd1,
        S_START = 4'd2,
        S_BIT   = 4'd3,
        S_STOP  = 4'd4,
        S_GAP   = 4'd5,
        S_WAIT  = 4'd6,
        S_DONE  = 4'd7,
        S_PWR1  = 4'd8,
        S_PWR2  = 4'd9
    } state_t;

    state_t          r_state;
    logic [c_QW-1:0] r_qcnt;
    logic [1:0]      r_q;
    logic [4:0]      r_bit;
    logic [26:0]     r_shift;
    logic [31:0]     r_wait;
    logic [7:0]      r_rom_idx;
    logic            r_sioc;
    logic            r_oe;
    logic            r_busy;
    logic            r_done;
    logic            r_auto;
    logic            w_qtick;
    logic [15:0]     w_entry;
`ifdef OV7670_PWR_SEQ_EN
    logic            r_pwdn;
    logic            r_resetb;
`endif

    // OV7670 RGB444 VGA set-up; FFF0 = delay, FFFF = end of table
    function automatic logic [15:0] f_rom(input logic [7:0] idx);
        case (idx)
            8'd0:    f_rom = 16'h1280;
            8'd1:    f_rom = 16'hFFF0;
            8'd2:    f_rom = 16'h1204;
            8'd3:    f_rom = 16'h8C02;
            8'd4:    f_rom = 16'h40D0;
            8'd5:    f_rom = 16'h3A04;
            8'd6:    f_rom = 16'h1101;
            8'd7:    f_rom = 16'h0C00;
            8'd8:    f_rom = 16'h3E00;
            8'd9:    f_rom = 16'h3DC0;
            8'd10:   f_rom = 16'h1713;
            8'd11:   f_rom = 16'h1801;
            8'd12:   f_rom = 16'h32B6;
            8'd13:   f_rom = 16'h1902;
            8'd14:   f_rom = 16'h1A7A;
            8'd15:   f_rom = 16'h030A;
            default: f_rom = 16'hFFFF;
        endcase
    endfunction

    assign w_entry = f_rom(r_rom_idx);
    assign w_qtick = (r_qcnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_qcnt    <= c_QRELOAD;
            r_q       <= 2'd0;
            r_bit     <= 5'd0;
            r_shift   <= '0;
            r_wait    <= 32'd0;
            r_rom_idx <= 8'd0;
            r_sioc    <= 1'b1;
            r_oe      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_auto    <= 1'b1;
`ifdef OV7670_PWR_SEQ_EN
            r_pwdn    <= 1'b1;
            r_resetb  <= 1'b0;
`endif
        end else begin
            r_auto <= 1'b0;
            r_qcnt <= w_qtick ? c_QRELOAD : r_qcnt - 1'b1;
            case (r_state)
                S_IDLE: begin
                    r_qcnt <= c_QRELOAD;
                    if (start || r_auto) begin
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                        r_rom_idx <= 8'd0;
`ifdef OV7670_PWR_SEQ_EN
                        r_pwdn    <= 1'b0;
                        r_resetb  <= 1'b0;
                        r_wait    <= c_MS_LOAD;
                        r_state   <= S_PWR1;
`else
                        r_state   <= S_FETCH;
`endif
                    end
                end
`ifdef OV7670_PWR_SEQ_EN
                S_PWR1: begin
                    r_qcnt <= c_QRELOAD;
                    if (r_wait == 32'd0) begin
                        r_resetb <= 1'b1;
                        r_wait   <= c_MS_LOAD;
                        r_state  <= S_PWR2;
                    end else begin
                        r_wait <= r_wait - 32'd1;
                    end
                end
                S_PWR2: begin
                    r_qcnt <= c_QRELOAD;
                    if (r_wait == 32'd0) r_state <= S_FETCH;
                    else                 r_wait  <= r_wait - 32'd1;
                end
`endif
                S_FETCH: begin
                    r_qcnt <= c_QRELOAD;
                    if (w_entry == 16'hFFFF) begin
                        r_state <= S_DONE;
                    end else if (w_entry == 16'hFFF0) begin
                        r_wait  <= c_WAIT_LOAD;
                        r_state <= S_WAIT;
                    end else begin
                        // don't-care bits are stored as 1 so they read back as released
                        r_shift <= {DEV_ADDR, 1'b1, w_entry[15:8], 1'b1, w_entry[7:0], 1'b1};
                        r_q     <= 2'd0;
                        r_bit   <= 5'd0;
                        r_state <= S_START;
                    end
                end
                S_START: if (w_qtick) begin
                    r_q <= r_q + 2'd1;
                    case (r_q)
                        2'd0:    r_oe   <= 1'b1;
                        2'd2:    r_sioc <= 1'b0;
                        2'd3: begin
                            r_oe    <= ~r_shift[26];
                            r_state <= S_BIT;
                        end
                        default: ;
                    endcase
                end
                S_BIT: if (w_qtick) begin
                    r_q <= r_q + 2'd1;
                    case (r_q)
                        2'd0:    r_sioc <= 1'b1;
                        2'd2:    r_sioc <= 1'b0;
                        2'd3: begin
                            if (r_bit == 5'd26) begin
                                r_oe    <= 1'b1;
                                r_state <= S_STOP;
                            end else begin
                                r_bit   <= r_bit + 5'd1;
                                r_shift <= {r_shift[25:0], 1'b1};
                                r_oe    <= ~r_shift[25];
                            end
                        end
                        default: ;
                    endcase
                end
                S_STOP: if (w_qtick) begin
                    r_q <= r_q + 2'd1;
                    case (r_q)
                        2'd0:    r_sioc <= 1'b1;
                        2'd1:    r_oe   <= 1'b0;
                        2'd3: begin
                            r_wait  <= c_GAP_LOAD;
                            r_state <= S_GAP;
                        end
                        default: ;
                    endcase
                end
                S_GAP: if (w_qtick) begin
                    if (r_wait == 32'd0) begin
                        r_rom_idx <= r_rom_idx + 8'd1;
                        r_state   <= (r_rom_idx == 8'hFF) ? S_DONE : S_FETCH;
                    end else begin
                        r_wait <= r_wait - 32'd1;
                    end
                end
                S_WAIT: begin
                    r_qcnt <= c_QRELOAD;
                    if (r_wait == 32'd0) begin
                        r_rom_idx <= r_rom_idx + 8'd1;
                        r_state   <= (r_rom_idx == 8'hFF) ? S_DONE : S_FETCH;
                    end else begin
                        r_wait <= r_wait - 32'd1;
                    end
                end
                S_DONE: begin
                    r_qcnt  <= c_QRELOAD;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_sioc  <= 1'b1;
                    r_oe    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign sioc    = r_sioc;
    assign siod_oe = r_oe;
    assign busy    = r_busy;
    assign done    = r_done;
    assign rom_idx = r_rom_idx;
`ifdef OV7670_PWR_SEQ_EN
    assign cam_pwdn   = r_pwdn;
    assign cam_resetb = r_resetb;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ov7670_sccb_config.sv
`default_nettype none
// ============================================================================
// Module      : tb_ov7670_sccb_config
// Description : Bench for ov7670_sccb_config. It holds an SCCB slave decoder and
//               a table-level timing model of the expected write sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ov7670_sccb_config;

    localparam int c_CLK_HZ     = 400_000;
    localparam int c_SCCB_HZ    = 100_000;
    localparam int c_DELAY_MS   = 1;
    localparam int c_GAP        = 4;
    localparam int c_QDIV       = c_CLK_HZ / (4 * c_SCCB_HZ);
    localparam int c_WRITE_CLKS = 1 + c_QDIV * (4 + 27 * 4 + 4 + c_GAP);
    localparam int c_DELAY_CLKS = 1 + c_DELAY_MS * c_CLK_HZ / 1000;
    localparam int c_BUDGET     = 8000;
`ifdef OV7670_PWR_SEQ_EN
    localparam int c_PWR_CLKS   = 2 * (c_CLK_HZ / 1000);
`else
    localparam int c_PWR_CLKS   = 0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       sioc;
    logic       siod_oe;
    logic       busy;
    logic       done;
    logic [7:0] rom_idx;
`ifdef OV7670_PWR_SEQ_EN
    logic       cam_pwdn;
    logic       cam_resetb;
`endif

    ov7670_sccb_config #(
        .CLK_FREQ_HZ  (c_CLK_HZ),
        .SCCB_FREQ_HZ (c_SCCB_HZ),
        .DEV_ADDR     (8'h42),
        .DELAY_MS     (c_DELAY_MS),
        .GAP_QTR      (c_GAP)
    ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .sioc    (sioc),
        .siod_oe (siod_oe),
        .busy    (busy),
        .done    (done),
        .rom_idx (rom_idx)
`ifdef OV7670_PWR_SEQ_EN
        ,
        .cam_pwdn   (cam_pwdn),
        .cam_resetb (cam_resetb)
`endif
    );

    initial forever #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic        p_sioc = 1'b1;
    logic        p_oe   = 1'b0;
    bit          in_frame = 1'b0;
    int          nbits  = 0;
    int          hi     = 0;
    logic [26:0] sh     = '0;
    logic [23:0] got[$];
    int          st[$];
    logic [15:0] table_q[$];
    logic [23:0] exp_w[$];
    int          exp_t[$];
    int          exp_busy;
    int          exp_end_idx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected writes and their START-condition offsets from the accepting clock
    task automatic build_model();
        int t;
        t = c_PWR_CLKS;
        exp_w.delete();
        exp_t.delete();
        exp_end_idx = -1;
        for (int i = 0; i < table_q.size(); i++) begin
            if (table_q[i] == 16'hFFFF) begin
                exp_end_idx = i;
                break;
            end
            if (table_q[i] == 16'hFFF0) begin
                t += c_DELAY_CLKS;
            end else begin
                exp_w.push_back({8'h42, table_q[i]});
                exp_t.push_back(t + 1 + c_QDIV);
                t += c_WRITE_CLKS;
            end
        end
        exp_busy = t + 2;
    endtask

    // One clock, sampled after the edge, feeding the SCCB slave decoder
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (!rst_n) begin
            in_frame = 1'b0;
            nbits    = 0;
        end else begin
            if (siod_oe !== p_oe) begin
                chk("siod_moves_with_sioc_stable", sioc, p_sioc);
                if (sioc && p_sioc) begin
                    if (siod_oe) begin
                        chk("start_cond_outside_frame", in_frame, 0);
                        in_frame = 1'b1;
                        nbits    = 0;
                        st.push_back(cyc);
                    end else begin
                        chk("stop_cond_after_27_bits", nbits, 27);
                        if (in_frame) got.push_back({sh[26:19], sh[17:10], sh[8:1]});
                        in_frame = 1'b0;
                    end
                end
            end
            if (sioc && !p_sioc && in_frame && nbits < 27) begin
                if (nbits == 8 || nbits == 17 || nbits == 26)
                    chk("ninth_bit_released", siod_oe, 0);
                sh = {sh[25:0], ~siod_oe};
                nbits++;
                hi = 0;
            end
            if (sioc) hi++;
            if (!sioc && p_sioc && in_frame && nbits > 0)
                chk("sioc_high_quarters", hi, 2 * c_QDIV);
        end
        p_sioc = sioc;
        p_oe   = siod_oe;
    endtask

    // Call on the first sample with busy=1; runs to completion and checks the result
    task automatic run_table(input bit inject, input string tag);
        int busy_n;
        int cyc0;
        busy_n = 0;
        cyc0   = cyc;
        got.delete();
        st.delete();
        while (busy === 1'b1 && busy_n < c_BUDGET) begin
            busy_n++;
            start = inject && ($urandom_range(0, 40) == 0);
            tick();
            start = 1'b0;
        end
        chk($sformatf("%s_busy_clks", tag), busy_n, exp_busy);
        chk($sformatf("%s_done", tag), done, 1);
        chk($sformatf("%s_idle_sioc", tag), sioc, 1);
        chk($sformatf("%s_idle_siod_oe", tag), siod_oe, 0);
        chk($sformatf("%s_end_idx", tag), rom_idx, exp_end_idx);
        chk($sformatf("%s_write_count", tag), got.size(), exp_w.size());
        for (int k = 0; k < exp_w.size(); k++) begin
            if (k < got.size()) chk($sformatf("%s_write%0d", tag, k), got[k], exp_w[k]);
            if (k < st.size())  chk($sformatf("%s_start_time%0d", tag, k), st[k] - cyc0, exp_t[k]);
        end
    endtask

    initial begin
        int n;
        table_q = '{16'h1280, 16'hFFF0, 16'h1204, 16'h8C02, 16'h40D0, 16'h3A04,
                    16'h1101, 16'h0C00, 16'h3E00, 16'h3DC0, 16'h1713, 16'h1801,
                    16'h32B6, 16'h1902, 16'h1A7A, 16'h030A, 16'hFFFF};
        build_model();

        // start coinciding with reset must lose
        rst_n = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat ($urandom_range(2, 5)) tick();
        chk("reset_sioc", sioc, 1);
        chk("reset_siod_oe", siod_oe, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_rom_idx", rom_idx, 0);

        rst_n = 1'b1;
        tick();
        chk("auto_start_busy", busy, 1);
        run_table(1'b0, "boot");

        repeat ($urandom_range(1, 20)) tick();
        chk("idle_done_sticky", done, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_done_cleared", done, 0);
        chk("restart_busy", busy, 1);
        run_table(1'b1, "rerun");

        // abort the third write partway through its data bits
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("abort_run_busy", busy, 1);
        got.delete();
        n = 0;
        while (!(got.size() == 2 && in_frame && nbits == 10 && !sioc) && n < c_BUDGET) begin
            tick();
            n++;
        end
        chk("abort_point_reached", n < c_BUDGET, 1);
        rst_n = 1'b0;
        tick();
        chk("abort_sioc", sioc, 1);
        chk("abort_siod_oe", siod_oe, 0);
        chk("abort_rom_idx", rom_idx, 0);
        chk("abort_busy", busy, 0);
        repeat ($urandom_range(1, 4)) tick();
        rst_n = 1'b1;
        tick();
        chk("resume_busy", busy, 1);
        run_table(1'b1, "resume");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
